// File: rtl/vector_delay_sel_div_pkg.sv
// Shared encodings and width helpers for the signed-digit delay/select block.
package vector_delay_sel_div_pkg;

  // Sequencer state encodings shared across the datapath slice.
  typedef enum logic [2:0] {
    START = 3'd0,
    FILL  = 3'd1,
    READY = 3'd2,
    HOLD  = 3'd3,
    FLUSH = 3'd4,
    END   = 3'd5
  } seq_state_e;

  // Width needed to hold a delay value in 0..max_delay.
  function automatic int dw_calc(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/vector_delay_sel_div_if.sv
// Handshake/data bundle between the iteration controller and the delay/select block.
interface vector_delay_sel_div_if #(
  parameter int UNROLLING      = 4,
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int DW             = 3
);
  logic                      enable;
  logic                      clear;
  logic                      in_valid;
  logic [UNROLLING-1:0]      x_vec_plus;
  logic [UNROLLING-1:0]      x_vec_minus;
  logic [DW-1:0]             delay_sel;
  logic                      fix_next_state;
  logic [RAM_ADDR_WIDTH+1:0] master_cnt;
  logic [RAM_ADDR_WIDTH-1:0] comp_cycle;
  logic [UNROLLING-1:0]      x_plus_chosen;
  logic [UNROLLING-1:0]      x_minus_chosen;
  logic                      out_valid;
  logic                      path_delayed;
  logic                      digit_err;
  logic [DW-1:0]             fill_cnt;
  logic                      last_cycle;

  modport master (
    output enable, clear, in_valid, x_vec_plus, x_vec_minus, delay_sel,
           fix_next_state, master_cnt, comp_cycle,
    input  x_plus_chosen, x_minus_chosen, out_valid, path_delayed,
           digit_err, fill_cnt, last_cycle
  );

  modport slave (
    input  enable, clear, in_valid, x_vec_plus, x_vec_minus, delay_sel,
           fix_next_state, master_cnt, comp_cycle,
    output x_plus_chosen, x_minus_chosen, out_valid, path_delayed,
           digit_err, fill_cnt, last_cycle
  );
endinterface

// File: rtl/sd_delay_line.sv
// Single-rail shift register with a selectable tap; sel == 0 bypasses to din.
module sd_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             asyn_reset_n,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] tap
);
  logic [DEPTH-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      stg <= '0;
    end else if (clear) begin
      stg <= '0;
    end else if (shift) begin
      stg[0] <= din;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  // sel is pre-clamped to DEPTH by the parent, so one stage always matches when sel != 0.
  always_comb begin
    tap = din;
    for (int k = 0; k < DEPTH; k++)
      if (sel == SW'(k + 1)) tap = stg[k];
  end
endmodule

// File: rtl/vector_delay_sel_div.sv
// Selects between a live and a programmably delayed signed-digit vector, normalising +1/-1 pairs.
module vector_delay_sel_div
  import vector_delay_sel_div_pkg::*;
#(
  parameter  int UNROLLING      = 4,
  parameter  int RAM_ADDR_WIDTH = 7,
  parameter  int MAX_DELAY      = 4,
  parameter  int WARMUP_CYCLES  = 4,
  localparam int DW             = dw_calc(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 asyn_reset_n,
  vector_delay_sel_div_if.slave bus
);
  localparam int             MW   = RAM_ADDR_WIDTH + 2;
  localparam logic [DW-1:0]  DMAX = DW'(MAX_DELAY);
  localparam logic [MW-1:0]  WARM = MW'(WARMUP_CYCLES);

  logic [DW-1:0]        dsel_clamp, dsel_q, fill_q;
  logic                 shift, err_q, last_q, dly_valid, sel_valid;
  logic [UNROLLING-1:0] tap_p, tap_m, raw_p, raw_m, both;

  assign dsel_clamp = (bus.delay_sel > DMAX) ? DMAX : bus.delay_sel;
  assign shift      = bus.enable && bus.in_valid;

  // A change of the latched delay restarts the fill count; stage data is kept.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      dsel_q <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      dsel_q <= dsel_clamp;
      last_q <= (bus.master_cnt == {2'b00, bus.comp_cycle});
      if (bus.clear) begin
        fill_q <= '0;
        err_q  <= 1'b0;
      end else begin
        if (dsel_clamp != dsel_q)
          fill_q <= '0;
        else if (shift && (fill_q < dsel_q))
          fill_q <= fill_q + DW'(1);
        if (bus.in_valid && |(bus.x_vec_plus & bus.x_vec_minus))
          err_q <= 1'b1;
      end
    end
  end

  sd_delay_line #(.WIDTH(UNROLLING), .DEPTH(MAX_DELAY), .SW(DW)) u_plus (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .clear        (bus.clear),
    .shift        (shift),
    .din          (bus.x_vec_plus),
    .sel          (dsel_q),
    .tap          (tap_p)
  );

  sd_delay_line #(.WIDTH(UNROLLING), .DEPTH(MAX_DELAY), .SW(DW)) u_minus (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .clear        (bus.clear),
    .shift        (shift),
    .din          (bus.x_vec_minus),
    .sel          (dsel_q),
    .tap          (tap_m)
  );

  assign bus.path_delayed = bus.fix_next_state || (bus.master_cnt < WARM);

  // With zero delay the tap is the live input, so the delayed path degenerates to it.
  assign dly_valid = (dsel_q == '0) ? bus.in_valid : (fill_q == dsel_q);
  assign sel_valid = asyn_reset_n && (bus.path_delayed ? dly_valid : bus.in_valid);
  assign raw_p     = bus.path_delayed ? tap_p : bus.x_vec_plus;
  assign raw_m     = bus.path_delayed ? tap_m : bus.x_vec_minus;
  assign both      = raw_p & raw_m;

  assign bus.x_plus_chosen  = sel_valid ? (raw_p & ~both) : '0;
  assign bus.x_minus_chosen = sel_valid ? (raw_m & ~both) : '0;
  assign bus.out_valid      = sel_valid;
  assign bus.digit_err      = err_q;
  assign bus.fill_cnt       = fill_q;
  assign bus.last_cycle     = last_q;
endmodule

// File: tb/tb_vector_delay_sel_div.sv
// Directed plus randomized checks of vector_delay_sel_div against a history-queue reference model.
module tb_vector_delay_sel_div;
  import vector_delay_sel_div_pkg::*;

  localparam int U   = 4;
  localparam int RAW = 7;
  localparam int MD  = 4;
  localparam int WU  = 4;
  localparam int DW  = dw_calc(MD);
  localparam int MW  = RAW + 2;

  logic clk = 1'b0;
  logic asyn_reset_n = 1'b0;
  always #5 clk = ~clk;

  vector_delay_sel_div_if #(.UNROLLING(U), .RAM_ADDR_WIDTH(RAW), .DW(DW)) bus ();

  vector_delay_sel_div #(
    .UNROLLING(U), .RAM_ADDR_WIDTH(RAW), .MAX_DELAY(MD), .WARMUP_CYCLES(WU)
  ) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .bus          (bus)
  );

  // Reference: h_p/h_m[k] = k-th most recent shifted vector; m_cnt = shifts since last restart.
  logic [U-1:0] h_p [MD];
  logic [U-1:0] h_m [MD];
  int m_dsel, m_cnt;
  bit m_err, m_last;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < MD; k++) begin h_p[k] = '0; h_m[k] = '0; end
    m_dsel = 0; m_cnt = 0; m_err = 0; m_last = 0;
  endtask

  task automatic check_model(input string tag);
    bit pd, v;
    int fill;
    logic [U-1:0] rp, rm, ep, em;
    pd   = bus.fix_next_state || (int'(bus.master_cnt) < WU);
    fill = (m_cnt < m_dsel) ? m_cnt : m_dsel;
    if (pd && m_dsel != 0) begin
      rp = h_p[m_dsel-1]; rm = h_m[m_dsel-1]; v = (fill == m_dsel);
    end else begin
      rp = bus.x_vec_plus; rm = bus.x_vec_minus; v = bus.in_valid;
    end
    if (!asyn_reset_n) v = 0;
    ep = v ? (rp & ~(rp & rm)) : '0;
    em = v ? (rm & ~(rp & rm)) : '0;
    chk({tag, ".valid"}, 32'(bus.out_valid),      32'(v));
    chk({tag, ".plus"},  32'(bus.x_plus_chosen),  32'(ep));
    chk({tag, ".minus"}, 32'(bus.x_minus_chosen), 32'(em));
    chk({tag, ".pd"},    32'(bus.path_delayed),   32'(pd));
    chk({tag, ".err"},   32'(bus.digit_err),      32'(m_err));
    chk({tag, ".fill"},  32'(bus.fill_cnt),       32'(fill));
    chk({tag, ".last"},  32'(bus.last_cycle),     32'(m_last));
  endtask

  task automatic model_clock();
    int c;
    bit sh;
    if (!asyn_reset_n) return;
    c  = (int'(bus.delay_sel) > MD) ? MD : int'(bus.delay_sel);
    sh = bus.enable && bus.in_valid;
    m_last = (int'(bus.master_cnt) == int'(bus.comp_cycle));
    if (bus.clear) begin
      for (int k = 0; k < MD; k++) begin h_p[k] = '0; h_m[k] = '0; end
      m_cnt = 0; m_err = 0;
    end else begin
      if (sh) begin
        for (int k = MD - 1; k > 0; k--) begin h_p[k] = h_p[k-1]; h_m[k] = h_m[k-1]; end
        h_p[0] = bus.x_vec_plus; h_m[0] = bus.x_vec_minus;
      end
      if (c != m_dsel) m_cnt = 0;
      else if (sh && m_cnt < 1000) m_cnt++;
      if (bus.in_valid && |(bus.x_vec_plus & bus.x_vec_minus)) m_err = 1;
    end
    m_dsel = c;
  endtask

  // Called at a negedge with inputs already applied.
  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    bus.enable = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b1;
    bus.x_vec_plus = 4'b1111; bus.x_vec_minus = 4'b0000;
    bus.delay_sel = '0; bus.fix_next_state = 1'b0;
    bus.master_cnt = MW'(10); bus.comp_cycle = '0;

    // Reset: outputs forced low even with a valid live input.
    #2;
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.plus",  32'(bus.x_plus_chosen), 0);
    chk("rst.fill",  32'(bus.fill_cnt), 0);
    chk("rst.pd0",   32'(bus.path_delayed), 0);
    @(negedge clk);
    bus.master_cnt = '0;
    #1 chk("rst.pd1", 32'(bus.path_delayed), 1);
    step("rst");
    asyn_reset_n = 1'b1;

    // Delay 2 fill from empty.
    bus.in_valid = 1'b0; bus.delay_sel = DW'(2); bus.master_cnt = '0;
    step("d2.latch");
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.x_vec_plus = U'(1 << i); bus.x_vec_minus = '0;
      #1;
      if (i < 2) chk("d2.notyet", 32'(bus.out_valid), 0);
      else begin
        chk("d2.valid", 32'(bus.out_valid), 1);
        chk("d2.plus",  32'(bus.x_plus_chosen), 'h1);
      end
      step("d2");
    end

    // Live path, same-cycle output.
    bus.master_cnt = MW'(10); bus.fix_next_state = 1'b0;
    bus.x_vec_plus = 4'b1010; bus.x_vec_minus = 4'b0101; bus.in_valid = 1'b1;
    #1;
    chk("live.plus",  32'(bus.x_plus_chosen), 'hA);
    chk("live.minus", 32'(bus.x_minus_chosen), 'h5);
    chk("live.pd",    32'(bus.path_delayed), 0);
    step("live");

    // Normalisation and sticky digit error.
    bus.x_vec_plus = 4'b0011; bus.x_vec_minus = 4'b0110;
    #1;
    chk("norm.plus",  32'(bus.x_plus_chosen), 'h1);
    chk("norm.minus", 32'(bus.x_minus_chosen), 'h4);
    step("norm");
    bus.x_vec_plus = 4'b1000; bus.x_vec_minus = 4'b0000;
    #1 chk("err.set", 32'(bus.digit_err), 1);
    step("err");
    #1 chk("err.sticky", 32'(bus.digit_err), 1);

    // Delay change 2 -> 3 on a full line restarts the fill.
    bus.master_cnt = '0;
    #1;
    chk("chg.full", 32'(bus.fill_cnt), 2);
    bus.in_valid = 1'b0; bus.delay_sel = DW'(3);
    step("chg");
    #1;
    chk("chg.fill0", 32'(bus.fill_cnt), 0);
    chk("chg.inv",   32'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.x_vec_plus = U'($urandom); bus.x_vec_minus = '0;
      #1 chk("chg.wait", 32'(bus.out_valid), 0);
      step("chg.fill");
    end
    #1;
    chk("chg.valid", 32'(bus.out_valid), 1);
    chk("chg.fill3", 32'(bus.fill_cnt), 3);

    // Clear beats a simultaneous shift.
    bus.clear = 1'b1; bus.enable = 1'b1; bus.in_valid = 1'b1;
    bus.x_vec_plus = 4'b1111; bus.x_vec_minus = 4'b0001;
    step("clr");
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("clr.fill", 32'(bus.fill_cnt), 0);
    chk("clr.err",  32'(bus.digit_err), 0);
    chk("clr.stgp", 32'(dut.u_plus.stg), 0);
    chk("clr.stgm", 32'(dut.u_minus.stg), 0);

    // last_cycle pulse, enable low.
    bus.enable = 1'b0; bus.comp_cycle = RAW'(5);
    for (int mc = 4; mc <= 6; mc++) begin
      bus.master_cnt = MW'(mc);
      step("last");
      #1 chk("last.pulse", 32'(bus.last_cycle), (mc == 5) ? 1 : 0);
    end

    // Out-of-range delay clamps to MAX_DELAY.
    bus.enable = 1'b1; bus.in_valid = 1'b1; bus.master_cnt = '0; bus.delay_sel = DW'(7);
    for (int i = 0; i < 6; i++) begin
      bus.x_vec_plus = U'($urandom); bus.x_vec_minus = '0;
      step("clamp");
    end
    #1 chk("clamp.fill", 32'(bus.fill_cnt), MD);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0) bus.delay_sel = DW'($urandom_range(7));
      bus.enable         = ($urandom_range(9) < 8);
      bus.in_valid       = ($urandom_range(9) < 7);
      bus.clear          = ($urandom_range(29) == 0);
      bus.fix_next_state = ($urandom_range(3) == 0);
      bus.master_cnt     = MW'($urandom_range(12));
      bus.comp_cycle     = RAW'($urandom_range(12));
      bus.x_vec_plus     = U'($urandom);
      bus.x_vec_minus    = ($urandom_range(3) == 0) ? U'($urandom) : U'($urandom) & ~bus.x_vec_plus;
      step("rnd");
    end

    // Reset mid-fill discards contents; refill from zero.
    bus.clear = 1'b0; bus.enable = 1'b1; bus.fix_next_state = 1'b0;
    bus.master_cnt = '0; bus.delay_sel = DW'(4); bus.in_valid = 1'b0;
    step("mid.latch");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.x_vec_plus = U'($urandom); bus.x_vec_minus = '0;
      step("mid.fill");
    end
    #2 asyn_reset_n = 1'b0;
    m_reset();
    #1;
    chk("mid.fill0", 32'(bus.fill_cnt), 0);
    chk("mid.stg",   32'(dut.u_plus.stg), 0);
    chk("mid.inv",   32'(bus.out_valid), 0);
    check_model("mid.rst");
    @(negedge clk);
    asyn_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.x_vec_plus = U'($urandom); bus.x_vec_minus = '0;
      step("mid.refill");
    end
    #1 chk("mid.full", 32'(bus.fill_cnt), MD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
